// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds:
//   - the canonical NOP encoding (addi x0, x0, 0), which is presented before the
//     first fetch and for fetches that were never sent to memory;
//   - the fetch FSM state encoding;
//   - the default reset PC.
package ifu_fetch_pkg;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] IFU_RST_PC = 32'h8000_0000;

  typedef enum logic [2:0] {
    IFU_IDLE = 3'd0,
    IFU_REQ  = 3'd1,
    IFU_WAIT = 3'd2,
    IFU_HOLD = 3'd3,
    IFU_DROP = 3'd4
  } ifu_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit feeding the decode stage.
// Holds the architectural PC and keeps one instruction-memory read in flight
// at a time. The fetched word is presented to decode with its PC. Redirects
// from execute (branches, jal/jalr, traps, mret) replace the PC; a fetch that
// is already in flight on the wrong path is drained and its data discarded.
//
// Ports:
//   clk, rst                 core clock, asynchronous active-high reset
//   jump_valid, jump_pc      one-cycle redirect pulse and its target
//   imem_req_valid/ready     fetch request handshake, address on imem_req_addr
//   imem_rsp_valid/ready     response handshake, imem_rsp_data / imem_rsp_err
//   inst_out, PC             instruction word and its PC for decode
//   inst_valid, inst_ready   decode handshake
//   fetch_fault              {misalign, access_fault} of the presented word
//
// Build option: IFU_MISALIGN_CHECK_EN. When defined, a redirect to a target
// that is not word aligned skips memory and presents a NOP flagged as a
// misaligned fetch. When undefined, the low two target bits are cleared and
// fetch_fault[1] is always 0.
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                  DATA_LEN = 32,
  parameter logic [DATA_LEN-1:0] RST_PC   = DATA_LEN'(IFU_RST_PC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                jump_valid,
  input  logic [DATA_LEN-1:0] jump_pc,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [DATA_LEN-1:0] imem_req_addr,
  input  logic                imem_rsp_valid,
  output logic                imem_rsp_ready,
  input  logic [31:0]         imem_rsp_data,
  input  logic                imem_rsp_err,
  output logic [31:0]         inst_out,
  output logic [DATA_LEN-1:0] PC,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [1:0]          fetch_fault
);

  localparam logic [DATA_LEN-1:0] PC_STEP    = DATA_LEN'(4);
  localparam logic [DATA_LEN-1:0] ALIGN_MASK = ~DATA_LEN'(3);

  ifu_state_e          state_reg, state_next;
  logic [DATA_LEN-1:0] pc_reg, pc_next;
  logic [DATA_LEN-1:0] redir_pc_reg, redir_pc_next;
  logic                redir_pend_reg, redir_pend_next;
  logic [31:0]         inst_reg, inst_next;
  logic [DATA_LEN-1:0] inst_pc_reg, inst_pc_next;
  logic [1:0]          fault_reg, fault_next;

  // Redirect bookkeeping shared by every state that restarts fetching.
  logic                take_redirect;
  logic [DATA_LEN-1:0] redirect_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IFU_IDLE;
      pc_reg         <= RST_PC;
      redir_pc_reg   <= RST_PC;
      redir_pend_reg <= 1'b0;
      inst_reg       <= NOP;
      inst_pc_reg    <= RST_PC;
      fault_reg      <= 2'b00;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      redir_pc_reg   <= redir_pc_next;
      redir_pend_reg <= redir_pend_next;
      inst_reg       <= inst_next;
      inst_pc_reg    <= inst_pc_next;
      fault_reg      <= fault_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    redir_pc_next   = redir_pc_reg;
    redir_pend_next = redir_pend_reg;
    inst_next       = inst_reg;
    inst_pc_next    = inst_pc_reg;
    fault_next      = fault_reg;
    take_redirect   = 1'b0;
    redirect_target = jump_pc;

    unique case (state_reg)
      IFU_IDLE: begin
        if (jump_valid) take_redirect = 1'b1;
        else            state_next    = IFU_REQ;
      end
      IFU_REQ: begin
        if (jump_valid) begin
          if (imem_req_ready) begin
            // The old address is already with memory: drain its response.
            redir_pc_next   = jump_pc;
            redir_pend_next = 1'b1;
            state_next      = IFU_DROP;
          end else begin
            // Not yet accepted, so the address may still change.
            take_redirect = 1'b1;
          end
        end else if (imem_req_ready) begin
          state_next = IFU_WAIT;
        end
      end
      IFU_WAIT: begin
        if (imem_rsp_valid) begin
          if (jump_valid) begin
            take_redirect = 1'b1;  // response consumed and thrown away
          end else begin
            inst_next    = imem_rsp_data;
            inst_pc_next = pc_reg;
            fault_next   = {1'b0, imem_rsp_err};
            state_next   = IFU_HOLD;
          end
        end else if (jump_valid) begin
          redir_pc_next   = jump_pc;
          redir_pend_next = 1'b1;
          state_next      = IFU_DROP;
        end
      end
      IFU_HOLD: begin
        // A redirect beats a simultaneous accept by decode.
        if (jump_valid) begin
          take_redirect = 1'b1;
        end else if (inst_ready) begin
          pc_next    = pc_reg + PC_STEP;
          state_next = IFU_REQ;
        end
      end
      IFU_DROP: begin
        if (imem_rsp_valid) begin
          take_redirect   = 1'b1;
          redirect_target = jump_valid ? jump_pc : redir_pc_reg;
        end else if (jump_valid) begin
          redir_pc_next = jump_pc;  // latest redirect wins
        end
      end
      default: state_next = IFU_IDLE;
    endcase

    if (take_redirect) begin
      redir_pend_next = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
      pc_next = redirect_target;
      if (redirect_target[1:0] != 2'b00) begin
        // Never sent to memory: present a NOP that decode will trap on.
        inst_next    = NOP;
        inst_pc_next = redirect_target;
        fault_next   = 2'b10;
        state_next   = IFU_HOLD;
      end else begin
        state_next = IFU_REQ;
      end
`else
      pc_next    = redirect_target & ALIGN_MASK;
      state_next = IFU_REQ;
`endif
    end
  end

  assign imem_req_valid = (state_reg == IFU_REQ);
  assign imem_req_addr  = pc_reg;
  assign imem_rsp_ready = (state_reg == IFU_WAIT) || (state_reg == IFU_DROP);
  assign inst_valid     = (state_reg == IFU_HOLD);
  assign inst_out       = inst_reg;
  assign PC             = inst_pc_reg;
  // Bit 1 can only be set by the misalign path, which is absent unless enabled.
  assign fetch_fault    = fault_reg;

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch. Acts as a single-outstanding instruction memory
// with configurable ready/latency and as the decode stage. A transaction-level
// model tracks which PC decode must see next: sequential +4 after each accept,
// jump target after each redirect, and the word/fault memory holds for it.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  localparam int          DL     = 32;
  localparam logic [31:0] RSTPC  = 32'h8000_0000;
  localparam logic [31:0] ERRADR = 32'h8000_0010;
`ifdef IFU_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          jump_valid = 1'b0;
  logic [DL-1:0] jump_pc = '0;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b0;
  logic [DL-1:0] imem_req_addr;
  logic          imem_rsp_valid = 1'b0;
  logic          imem_rsp_ready;
  logic [31:0]   imem_rsp_data = '0;
  logic          imem_rsp_err = 1'b0;
  logic [31:0]   inst_out;
  logic [DL-1:0] PC;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [1:0]    fetch_fault;

  ifu_fetch #(.DATA_LEN(DL), .RST_PC(RSTPC)) dut (
    .clk(clk), .rst(rst),
    .jump_valid(jump_valid), .jump_pc(jump_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst_out(inst_out), .PC(PC), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Stimulus controls.
  bit          ready_always = 1'b1;
  int          ready_pct    = 100;
  int          lat_lo = 0, lat_hi = 0;
  int          jump_pct = 0;
  bit          jv = 1'b0;
  logic [31:0] jt = '0;
  bit          ir = 1'b1;
  int          ir_pct = 100;
  logic [31:0] bad_addr = 32'h0;

  // Memory model.
  bit          mem_busy = 1'b0;
  int          mem_lat  = 0;
  logic [31:0] mem_addr = '0;

  // Reference model and protocol history.
  logic [31:0] exp_pc = RSTPC;
  bit          pend_prev = 1'b0, jump_prev = 1'b0;
  logic [31:0] addr_prev = '0;
  int          req_cycles[$];
  logic [31:0] req_addrs[$];
  int          vld_cycles[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == bad_addr)      return 32'hDEAD_BEEF;
    if (a < 32'h8000_0010)  return 32'h0000_0093;
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] p);
    if (MIS_EN && p[1:0] != 2'b00) return NOP;
    return mem_data(p);
  endfunction

  function automatic logic [31:0] exp_fault(input logic [31:0] p);
    if (MIS_EN && p[1:0] != 2'b00) return 32'd2;
    return {31'd0, p == ERRADR};
  endfunction

  function automatic logic [31:0] jump_model(input logic [31:0] t);
    return MIS_EN ? t : {t[31:2], 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    cyc++;
    if (inst_valid) begin
      vld_cycles.push_back(cyc);
      chk("model_pc", PC, exp_pc);
      chk("model_inst", inst_out, exp_inst(exp_pc));
      chk("model_fault", {30'd0, fetch_fault}, exp_fault(exp_pc));
    end
    if (pend_prev) begin
      chk("req_held_valid", {31'd0, imem_req_valid}, 32'd1);
      if (!jump_prev) chk("req_held_addr", imem_req_addr, addr_prev);
    end
    imem_req_ready = !mem_busy && (ready_always || ($urandom_range(99, 0) < ready_pct));
    imem_rsp_valid = mem_busy && (mem_lat == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_data(mem_addr) : $urandom;
    imem_rsp_err   = imem_rsp_valid ? (mem_addr == ERRADR) : 1'($urandom_range(1, 0));
    jump_valid     = jv;
    jump_pc        = jv ? jt : $urandom;
    inst_ready     = ir;
    if (imem_rsp_valid && imem_rsp_ready) mem_busy = 1'b0;
    else if (mem_busy && mem_lat != 0)   mem_lat--;
    if (imem_req_valid && imem_req_ready) begin
      mem_busy = 1'b1;
      mem_addr = imem_req_addr;
      mem_lat  = $urandom_range(lat_hi, lat_lo);
      req_cycles.push_back(cyc);
      req_addrs.push_back(imem_req_addr);
    end
    pend_prev = imem_req_valid && !imem_req_ready;
    jump_prev = jump_valid;
    addr_prev = imem_req_addr;
    if (jump_valid) begin
      exp_pc = jump_model(jump_pc);
    end else if (inst_valid && inst_ready) begin
      $display("accept pc=%h inst=%h fault=%b", PC, inst_out, fetch_fault);
      exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // 0: inst_valid, 1: imem_req_valid, 2: imem_rsp_ready
  task automatic wait_for(input int which, input string tag);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 60; n++) begin
      hit = (which == 0) ? inst_valid : (which == 1) ? imem_req_valid : imem_rsp_ready;
      if (hit) break;
      step();
    end
    chk(tag, {31'd0, hit}, 32'd1);
  endtask

  task automatic jump_step(input logic [31:0] target);
    jv = 1'b1; jt = target;
    step();
    jv = 1'b0;
  endtask

  logic [31:0] hold_inst, hold_pc;

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_rsp_ready", {31'd0, imem_rsp_ready}, 32'd0);
    chk("rst_fault", {30'd0, fetch_fault}, 32'd0);
    chk("rst_inst_out", inst_out, NOP);
    chk("rst_PC", PC, RSTPC);
    chk("rst_req_addr", imem_req_addr, RSTPC);

    // Zero-wait sequential fetch.
    rst = 1'b0;
    cyc = 0;
    repeat (10) step();
    chk("zw_nreq", req_cycles.size(), 32'd3);
    chk("zw_nvalid", vld_cycles.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("zw_req_cycle", req_cycles[i], 2 + 3 * i);
      chk("zw_req_addr", req_addrs[i], RSTPC + 32'(4 * i));
      chk("zw_valid_cycle", vld_cycles[i], 4 + 3 * i);
    end

    // Decode stalls for 5 cycles.
    ir = 1'b0;
    wait_for(0, "stall_reach_hold");
    hold_inst = inst_out;
    hold_pc   = PC;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_inst", inst_out, hold_inst);
      chk("stall_pc", PC, hold_pc);
      chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    ir = 1'b1;

    // Redirect in WAIT with the response in the same cycle.
    wait_for(2, "wait_reach");
    bad_addr = mem_addr;
    jump_step(32'h8000_0100);
    chk("wait_jump_req", {31'd0, imem_req_valid}, 32'd1);
    chk("wait_jump_addr", imem_req_addr, 32'h8000_0100);
    wait_for(0, "wait_jump_present");
    chk("wait_jump_pc", PC, 32'h8000_0100);
    chk("no_stale_data", {31'd0, inst_out == 32'hDEAD_BEEF}, 32'd0);

    // Redirect in WAIT before a slow response: drained, then refetch.
    lat_lo = 3; lat_hi = 3;
    wait_for(2, "drop_reach");
    jump_step(32'h8000_0180);
    wait_for(1, "drop_req");
    chk("drop_addr", imem_req_addr, 32'h8000_0180);
    lat_lo = 0; lat_hi = 0;

    // Redirect and accept in the same HOLD cycle.
    wait_for(0, "hold_reach");
    jump_step(32'h8000_0040);
    chk("hold_jump_valid", {31'd0, inst_valid}, 32'd0);
    wait_for(1, "hold_jump_req");
    chk("hold_jump_addr", imem_req_addr, 32'h8000_0040);

    // Access fault.
    wait_for(0, "err_hold");
    jump_step(ERRADR);
    wait_for(0, "err_present");
    chk("err_fault", {30'd0, fetch_fault}, 32'd1);
    chk("err_pc", PC, ERRADR);

    // Misaligned redirect.
    jump_step(32'h8000_0022);
`ifdef IFU_MISALIGN_CHECK_EN
    chk("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
    chk("mis_valid", {31'd0, inst_valid}, 32'd1);
    chk("mis_inst", inst_out, NOP);
    chk("mis_fault", {30'd0, fetch_fault}, 32'd2);
    chk("mis_pc", PC, 32'h8000_0022);
    jump_step(32'h8000_0200);
`else
    wait_for(1, "mis_req");
    chk("mis_addr", imem_req_addr, 32'h8000_0020);
`endif

    // Randomized traffic against the model.
    ready_always = 1'b0;
    ready_pct = 70; ir_pct = 70; jump_pct = 6;
    lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 1500; i++) begin
      ir = ($urandom_range(99, 0) < ir_pct);
      jv = ($urandom_range(99, 0) < jump_pct);
      jt = 32'h8000_0000 | (32'($urandom_range(255, 0)) << 2);
      step();
    end
    jv = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
